// File: rtl/rx_tdm_channel_mixer.sv
`default_nettype none
// ============================================================================
// Module   : rx_tdm_channel_mixer
// Purpose  : TDM complex mixer. Per-channel NCO (phase accumulator plus
//            increment) rotates each tagged I/Q sample up or down, then the
//            result is rounded back to sample width. Six-stage pipeline,
//            one sample per cycle, any channel order.
// Build    : RX_MIXER_SATURATE_EN defined   -> out-of-range results clamp
//            RX_MIXER_SATURATE_EN undefined -> out-of-range results wrap
// Revision : 1.0  initial release
// ============================================================================
module rx_tdm_channel_mixer #(
  parameter int WIDTH       = 16,
  parameter int COEF_WIDTH  = 18,
  parameter int NUM_CH      = 4,
  parameter int PHASE_WIDTH = 24,
  parameter int LUT_ADDR    = 10,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic signed [WIDTH-1:0] i_inph,
  input  logic signed [WIDTH-1:0] i_quad,
  input  logic [CH_W-1:0]         i_chan,
  input  logic                    i_valid,
  input  logic                    i_dir,
  input  logic [CH_W-1:0]         i_cfg_chan,
  input  logic [PHASE_WIDTH-1:0]  i_cfg_phase_inc,
  input  logic                    i_cfg_inc_wr,
  input  logic                    i_cfg_clr,
  output logic signed [WIDTH-1:0] o_inph,
  output logic signed [WIDTH-1:0] o_quad,
  output logic [CH_W-1:0]         o_chan,
  output logic                    o_inph_oflow,
  output logic                    o_quad_oflow,
  output logic                    o_valid
);

  localparam int c_lut_n  = 1 << LUT_ADDR;
  localparam int c_prod_w = WIDTH + COEF_WIDTH;
  localparam int c_sum_w  = c_prod_w + 1;
  localparam int c_rnd_w  = c_sum_w - (COEF_WIDTH - 1);
  // Half an output LSB, added before the truncating shift (round half up)
  localparam logic signed [c_sum_w-1:0] c_half =
    {{(c_sum_w-COEF_WIDTH+1){1'b0}}, 1'b1, {(COEF_WIDTH-2){1'b0}}};

  // Full-cycle sin/cos coefficient, amplitude 2^(COEF_WIDTH-1)-1, nearest.
  function automatic logic signed [COEF_WIDTH-1:0] f_lut(input int k, input bit sin_sel);
    real         ang;
    real         amp;
    real         v;
    int          n;
    logic [31:0] n_bits;
    ang    = 2.0 * 3.14159265358979323846 * real'(k) / real'(c_lut_n);
    amp    = real'((1 << (COEF_WIDTH - 1)) - 1);
    v      = sin_sel ? $sin(ang) * amp : $cos(ang) * amp;
    n      = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    n_bits = n;
    return n_bits[COEF_WIDTH-1:0];
  endfunction

  logic signed [COEF_WIDTH-1:0] w_cos_tab [c_lut_n];
  logic signed [COEF_WIDTH-1:0] w_sin_tab [c_lut_n];

  for (genvar gk = 0; gk < c_lut_n; gk++) begin : g_lut
    localparam logic signed [COEF_WIDTH-1:0] c_cos = f_lut(gk, 1'b0);
    localparam logic signed [COEF_WIDTH-1:0] c_sin = f_lut(gk, 1'b1);
    assign w_cos_tab[gk] = c_cos;
    assign w_sin_tab[gk] = c_sin;
  end

  // Per-channel NCO state
  logic [PHASE_WIDTH-1:0] r_acc [NUM_CH];
  logic [PHASE_WIDTH-1:0] r_inc [NUM_CH];
  logic [LUT_ADDR-1:0]    w_addr_sel;

  // Pipeline registers
  logic [4:0]                   r_vld;
  logic [CH_W-1:0]              r_chn [5];
  logic [LUT_ADDR-1:0]          r_s0_addr;
  logic signed [WIDTH-1:0]      r_s0_i, r_s0_q, r_s1_i, r_s1_q;
  logic                         r_s0_dir, r_s1_dir, r_s2_dir;
  logic signed [COEF_WIDTH-1:0] r_s1_cos, r_s1_sin;
  logic signed [c_prod_w-1:0]   r_s2_ic, r_s2_qs, r_s2_qc, r_s2_is;
  logic signed [c_sum_w-1:0]    r_s3_i, r_s3_q;
  logic signed [c_rnd_w-1:0]    r_s4_i, r_s4_q;

  // Combinational helpers
  logic signed [c_prod_w-1:0] w_i_x, w_q_x, w_cos_x, w_sin_x;
  logic signed [c_sum_w-1:0]  w_ic_x, w_qs_x, w_qc_x, w_is_x;
  logic signed [c_sum_w-1:0]  w_i_h, w_q_h;
  logic                       w_ofl_i, w_ofl_q;
  logic                       w_unused_round_lsbs;

  // Table address of the tagged channel; a tag beyond NUM_CH reads phase 0
  always_comb begin
    w_addr_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_chan == k[CH_W-1:0]) w_addr_sel = r_acc[k][PHASE_WIDTH-1 -: LUT_ADDR];
    end
  end

  // NCO update: advance on a sample with the old increment, clear beats advance
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_acc[k] <= '0;
        r_inc[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_cfg_clr && (i_cfg_chan == k[CH_W-1:0])) begin
          r_acc[k] <= '0;
        end else if (i_valid && (i_chan == k[CH_W-1:0])) begin
          r_acc[k] <= r_acc[k] + r_inc[k];
        end
        if (i_cfg_inc_wr && (i_cfg_chan == k[CH_W-1:0])) begin
          r_inc[k] <= i_cfg_phase_inc;
        end
      end
    end
  end

  // Sign-extended operands so the products are formed at full precision
  assign w_i_x   = {{COEF_WIDTH{r_s1_i[WIDTH-1]}}, r_s1_i};
  assign w_q_x   = {{COEF_WIDTH{r_s1_q[WIDTH-1]}}, r_s1_q};
  assign w_cos_x = {{WIDTH{r_s1_cos[COEF_WIDTH-1]}}, r_s1_cos};
  assign w_sin_x = {{WIDTH{r_s1_sin[COEF_WIDTH-1]}}, r_s1_sin};

  assign w_ic_x = {r_s2_ic[c_prod_w-1], r_s2_ic};
  assign w_qs_x = {r_s2_qs[c_prod_w-1], r_s2_qs};
  assign w_qc_x = {r_s2_qc[c_prod_w-1], r_s2_qc};
  assign w_is_x = {r_s2_is[c_prod_w-1], r_s2_is};

  assign w_i_h = r_s3_i + c_half;
  assign w_q_h = r_s3_q + c_half;
  // Fraction bits below the output LSB are dropped by the shift
  assign w_unused_round_lsbs = ^{w_i_h[COEF_WIDTH-2:0], w_q_h[COEF_WIDTH-2:0]};

  // Rounded value fits only when all bits above the output sign agree
  assign w_ofl_i = !((&r_s4_i[c_rnd_w-1:WIDTH-1]) || !(|r_s4_i[c_rnd_w-1:WIDTH-1]));
  assign w_ofl_q = !((&r_s4_q[c_rnd_w-1:WIDTH-1]) || !(|r_s4_q[c_rnd_w-1:WIDTH-1]));

  // Valid pipeline S0..S4; reset drops every sample in flight
  always_ff @(posedge i_clock) begin
    if (i_reset) r_vld <= '0;
    else         r_vld <= {r_vld[3:0], i_valid};
  end

  // Datapath S0..S4: address, table read, multiply, add/sub, round
  always_ff @(posedge i_clock) begin
    r_s0_addr <= w_addr_sel;
    r_s0_i    <= i_inph;
    r_s0_q    <= i_quad;
    r_s0_dir  <= i_dir;
    r_chn[0]  <= i_chan;
    for (int k = 1; k < 5; k++) r_chn[k] <= r_chn[k-1];

    r_s1_cos <= w_cos_tab[r_s0_addr];
    r_s1_sin <= w_sin_tab[r_s0_addr];
    r_s1_i   <= r_s0_i;
    r_s1_q   <= r_s0_q;
    r_s1_dir <= r_s0_dir;

    r_s2_ic  <= w_i_x * w_cos_x;
    r_s2_qs  <= w_q_x * w_sin_x;
    r_s2_qc  <= w_q_x * w_cos_x;
    r_s2_is  <= w_i_x * w_sin_x;
    r_s2_dir <= r_s1_dir;

    // dir=0 multiplies by e^-j(theta), dir=1 by e^+j(theta)
    r_s3_i <= r_s2_dir ? (w_ic_x - w_qs_x) : (w_ic_x + w_qs_x);
    r_s3_q <= r_s2_dir ? (w_qc_x + w_is_x) : (w_qc_x - w_is_x);

    r_s4_i <= w_i_h[c_sum_w-1:COEF_WIDTH-1];
    r_s4_q <= w_q_h[c_sum_w-1:COEF_WIDTH-1];
  end

`ifdef RX_MIXER_SATURATE_EN
  localparam logic [WIDTH-1:0] c_max = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // S5 output register: fit to WIDTH, hold value while idle
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid      <= 1'b0;
      o_inph       <= '0;
      o_quad       <= '0;
      o_chan       <= '0;
      o_inph_oflow <= 1'b0;
      o_quad_oflow <= 1'b0;
    end else begin
      o_valid <= r_vld[4];
      if (r_vld[4]) begin
`ifdef RX_MIXER_SATURATE_EN
        o_inph <= w_ofl_i ? (r_s4_i[c_rnd_w-1] ? c_min : c_max) : r_s4_i[WIDTH-1:0];
        o_quad <= w_ofl_q ? (r_s4_q[c_rnd_w-1] ? c_min : c_max) : r_s4_q[WIDTH-1:0];
`else
        o_inph <= r_s4_i[WIDTH-1:0];
        o_quad <= r_s4_q[WIDTH-1:0];
`endif
        o_chan       <= r_chn[4];
        o_inph_oflow <= w_ofl_i;
        o_quad_oflow <= w_ofl_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_tdm_channel_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_tdm_channel_mixer
// Purpose  : Self-checking bench for rx_tdm_channel_mixer. A reference model
//            of per-channel phase, complex rotation and rounding predicts
//            every output; directed scenarios plus a randomized run.
// Revision : 1.0  initial release
// ============================================================================
module tb_rx_tdm_channel_mixer;

  localparam int     WIDTH       = 16;
  localparam int     COEF_WIDTH  = 18;
  localparam int     NUM_CH      = 4;
  localparam int     PHASE_WIDTH = 24;
  localparam int     LUT_ADDR    = 10;
  localparam int     CH_W        = 2;
  localparam int     LAT         = 6;
  localparam longint QTR         = 64'd4194304;
  localparam longint OCT         = 64'd2097152;
`ifdef RX_MIXER_SATURATE_EN
  localparam longint EXP45       = 32767;
`else
  localparam longint EXP45       = -19197;
`endif

  logic                    i_clock         = 1'b0;
  logic                    i_reset         = 1'b1;
  logic signed [WIDTH-1:0] i_inph          = '0;
  logic signed [WIDTH-1:0] i_quad          = '0;
  logic [CH_W-1:0]         i_chan          = '0;
  logic                    i_valid         = 1'b0;
  logic                    i_dir           = 1'b0;
  logic [CH_W-1:0]         i_cfg_chan      = '0;
  logic [PHASE_WIDTH-1:0]  i_cfg_phase_inc = '0;
  logic                    i_cfg_inc_wr    = 1'b0;
  logic                    i_cfg_clr       = 1'b0;
  logic signed [WIDTH-1:0] o_inph;
  logic signed [WIDTH-1:0] o_quad;
  logic [CH_W-1:0]         o_chan;
  logic                    o_inph_oflow;
  logic                    o_quad_oflow;
  logic                    o_valid;

  rx_tdm_channel_mixer #(
    .WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .NUM_CH(NUM_CH),
    .PHASE_WIDTH(PHASE_WIDTH), .LUT_ADDR(LUT_ADDR)
  ) u_dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_inph(i_inph), .i_quad(i_quad), .i_chan(i_chan), .i_valid(i_valid), .i_dir(i_dir),
    .i_cfg_chan(i_cfg_chan), .i_cfg_phase_inc(i_cfg_phase_inc),
    .i_cfg_inc_wr(i_cfg_inc_wr), .i_cfg_clr(i_cfg_clr),
    .o_inph(o_inph), .o_quad(o_quad), .o_chan(o_chan),
    .o_inph_oflow(o_inph_oflow), .o_quad_oflow(o_quad_oflow), .o_valid(o_valid)
  );

  always #5 i_clock = ~i_clock;

  typedef struct { longint i; longint q; int ch; bit fi; bit fq; longint cyc; } exp_t;

  int              n_total = 0;
  int              n_pass  = 0;
  longint          cyc     = 0;
  longint unsigned m_acc [NUM_CH];
  longint unsigned m_inc [NUM_CH];
  exp_t            exp_q  [$];
  exp_t            hist_q [$];

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Rotation coefficient at a table index, scaled and rounded to nearest
  function automatic longint coef(input longint idx, input bit use_sin);
    real th;
    real v;
    th = 2.0 * 3.14159265358979323846 * real'(idx) / real'(2 ** LUT_ADDR);
    v  = (use_sin ? $sin(th) : $cos(th)) * real'(2 ** (COEF_WIDTH - 1) - 1);
    return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
  endfunction

  function automatic longint fit(input longint r);
    longint w;
`ifdef RX_MIXER_SATURATE_EN
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return r;
`else
    w = r & 64'hFFFF;
    if (w >= 32768) w = w - 65536;
    return w;
`endif
  endfunction

  // Expected output for sample (ii,qq) rotated by the given accumulator phase
  function automatic exp_t predict(input longint ii, input longint qq, input bit dir,
                                   input longint unsigned phase, input int ch);
    exp_t   e;
    longint c, s, si, sq, ri, rq;
    c  = coef(longint'(phase >> (PHASE_WIDTH - LUT_ADDR)), 1'b0);
    s  = coef(longint'(phase >> (PHASE_WIDTH - LUT_ADDR)), 1'b1);
    si = dir ? (ii * c - qq * s) : (ii * c + qq * s);
    sq = dir ? (qq * c + ii * s) : (qq * c - ii * s);
    ri = (si + (64'sd1 <<< (COEF_WIDTH - 2))) >>> (COEF_WIDTH - 1);
    rq = (sq + (64'sd1 <<< (COEF_WIDTH - 2))) >>> (COEF_WIDTH - 1);
    e.fi  = (ri > 32767) || (ri < -32768);
    e.fq  = (rq > 32767) || (rq < -32768);
    e.i   = fit(ri);
    e.q   = fit(rq);
    e.ch  = ch;
    e.cyc = 0;
    return e;
  endfunction

  task automatic observe();
    exp_t e;
    exp_t o;
    if (o_valid === 1'b1) begin
      o.i = o_inph; o.q = o_quad; o.ch = int'(o_chan);
      o.fi = o_inph_oflow; o.fq = o_quad_oflow; o.cyc = cyc;
      hist_q.push_back(o);
      if (exp_q.size() == 0) begin
        check("spurious_valid", o_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("latency", cyc, e.cyc);
        check("inph", o_inph, e.i);
        check("quad", o_quad, e.q);
        check("chan", o_chan, e.ch);
        check("inph_oflow", o_inph_oflow, e.fi);
        check("quad_oflow", o_quad_oflow, e.fq);
      end
    end
  endtask

  // Observe on the falling edge, then step past the next rising edge
  task automatic tick();
    @(negedge i_clock);
    observe();
    @(posedge i_clock);
    cyc++;
    #1;
  endtask

  task automatic drive(input bit v, input int ch, input longint ii, input longint qq, input bit dir,
                       input bit wr, input bit clr, input int cch, input longint unsigned cinc);
    exp_t e;
    tick();
    i_valid = v; i_chan = ch[CH_W-1:0]; i_inph = ii[WIDTH-1:0]; i_quad = qq[WIDTH-1:0];
    i_dir = dir; i_cfg_inc_wr = wr; i_cfg_clr = clr; i_cfg_chan = cch[CH_W-1:0];
    i_cfg_phase_inc = cinc[PHASE_WIDTH-1:0];
    if (v) begin
      e = predict(ii, qq, dir, m_acc[ch], ch);
      e.cyc = cyc + LAT;
      exp_q.push_back(e);
      m_acc[ch] = (m_acc[ch] + m_inc[ch]) % (64'd1 << PHASE_WIDTH);
    end
    if (clr) m_acc[cch] = 0;
    if (wr)  m_inc[cch] = cinc % (64'd1 << PHASE_WIDTH);
  endtask

  task automatic sample(input int ch, input longint ii, input longint qq, input bit dir);
    drive(1'b1, ch, ii, qq, dir, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Clear the accumulator and load an increment in one cycle
  task automatic setup(input int ch, input longint unsigned inc);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, ch, inc);
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      idle();
    end
    idle();
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic expect_hist(input int idx, input string tag, input longint ei, input longint eq, input int ech);
    if (idx >= hist_q.size()) begin
      check({tag, "_missing"}, hist_q.size(), idx + 1);
      return;
    end
    check({tag, "_i"}, hist_q[idx].i, ei);
    check({tag, "_q"}, hist_q[idx].q, eq);
    check({tag, "_ch"}, hist_q[idx].ch, ech);
  endtask

  task automatic do_reset();
    tick();
    i_reset = 1'b1; i_valid = 1'b0; i_cfg_inc_wr = 1'b0; i_cfg_clr = 1'b0;
    tick();
    exp_q.delete();
    for (int k = 0; k < NUM_CH; k++) begin
      m_acc[k] = 0;
      m_inc[k] = 0;
    end
    check("rst_valid", o_valid, 0);
    check("rst_inph", o_inph, 0);
    check("rst_quad", o_quad, 0);
    check("rst_chan", o_chan, 0);
    check("rst_iofl", o_inph_oflow, 0);
    check("rst_qofl", o_quad_oflow, 0);
    i_reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Identity: zero phase passes the sample straight through
    hist_q.delete();
    sample(0, 1000, 0, 1'b0);
    drain();
    expect_hist(0, "ident", 1000, 0, 0);

    // Quarter-turn, down then up
    setup(0, QTR);
    hist_q.delete();
    for (int k = 0; k < 4; k++) sample(0, 1000, 0, 1'b0);
    drain();
    expect_hist(0, "qdn0", 1000, 0, 0);
    expect_hist(1, "qdn1", 0, -1000, 0);
    expect_hist(2, "qdn2", -1000, 0, 0);
    expect_hist(3, "qdn3", 0, 1000, 0);
    setup(0, QTR);
    hist_q.delete();
    for (int k = 0; k < 4; k++) sample(0, 1000, 0, 1'b1);
    drain();
    expect_hist(1, "qup1", 0, 1000, 0);
    expect_hist(3, "qup3", 0, -1000, 0);

    // Overflow at 45 degrees
    setup(0, OCT);
    hist_q.delete();
    sample(0, 32767, 32767, 1'b0);
    sample(0, 32767, 32767, 1'b0);
    drain();
    expect_hist(1, "ofl45", EXP45, 0, 0);
    if (hist_q.size() > 1) check("ofl45_flag", hist_q[1].fi, 1);

    // TDM independence: ch0 rotates, ch1 stays put
    setup(0, QTR);
    setup(1, 0);
    hist_q.delete();
    for (int k = 0; k < 8; k++) sample(k % 2, 1000, 0, 1'b0);
    drain();
    expect_hist(0, "tdm0", 1000, 0, 0);
    expect_hist(1, "tdm1", 1000, 0, 1);
    expect_hist(2, "tdm2", 0, -1000, 0);
    expect_hist(4, "tdm4", -1000, 0, 0);
    expect_hist(6, "tdm6", 0, 1000, 0);
    expect_hist(7, "tdm7", 1000, 0, 1);

    // Same-cycle increment write and sample on ch2
    setup(2, 0);
    hist_q.delete();
    drive(1'b1, 2, 1000, 0, 1'b0, 1'b1, 1'b0, 2, QTR);
    sample(2, 1000, 0, 1'b0);
    sample(2, 1000, 0, 1'b0);
    // acc[2] now at 180 degrees; sample with a same-cycle clear
    drive(1'b1, 2, 1000, 0, 1'b0, 1'b0, 1'b1, 2, 0);
    sample(2, 1000, 0, 1'b0);
    drain();
    expect_hist(0, "sc0", 1000, 0, 2);
    expect_hist(1, "sc1", 1000, 0, 2);
    expect_hist(2, "sc2", 0, -1000, 2);
    expect_hist(3, "sclr0", -1000, 0, 2);
    expect_hist(4, "sclr1", 1000, 0, 2);

    // Reset with three samples in flight
    setup(0, QTR);
    sample(0, 1000, 0, 1'b0);
    sample(0, 1000, 0, 1'b0);
    sample(0, 1000, 0, 1'b0);
    hist_q.delete();
    do_reset();
    for (int k = 0; k < 10; k++) idle();
    check("rst_flush_count", hist_q.size(), 0);
    check("rst_hold_inph", o_inph, 0);
    sample(0, 1000, 0, 1'b0);
    drain();
    expect_hist(0, "post_rst", 1000, 0, 0);

    // Randomized traffic, config writes and clears
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(3) != 0, int'($urandom_range(NUM_CH - 1)),
            longint'($urandom_range(65535)) - 32768, longint'($urandom_range(65535)) - 32768,
            $urandom_range(1) == 1, $urandom_range(7) == 0, $urandom_range(9) == 0,
            int'($urandom_range(NUM_CH - 1)), longint'($urandom) & 64'hFFFFFF);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_tdm_channel_mixer.md
# rx_tdm_channel_mixer

Time-division-multiplexed complex mixer: the parametrised successor to the single-channel Rx channel modulator. Each input sample carries a channel tag. The block keeps a private phase accumulator and frequency increment per channel, rotates the sample by the NCO phase in the selected direction, and rounds the result back to sample width. It sits between the Rx channeliser and the per-channel demodulators and serves up to NUM_CH interleaved channels on one multiplier set.

## Interface
- WIDTH, 16, I/Q sample width (signed)
- COEF_WIDTH, 18, sin/cos coefficient width (signed)
- NUM_CH, 4, number of TDM channels (≥1); CH_W = max(1, $clog2(NUM_CH))
- PHASE_WIDTH, 24, phase accumulator width
- LUT_ADDR, 10, sin/cos table address bits (≤ PHASE_WIDTH)
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_inph, i_quad  in  WIDTH  input sample
- i_chan  in  CH_W  channel tag of input sample
- i_valid  in  1  sample strobe; no backpressure
- i_dir  in  1  0 = down-convert (×e^-jθ), 1 = up-convert (×e^+jθ); sampled with i_valid
- i_cfg_chan  in  CH_W  channel addressed by config write
- i_cfg_phase_inc  in  PHASE_WIDTH  new increment, unsigned
- i_cfg_inc_wr  in  1  write increment for i_cfg_chan
- i_cfg_clr  in  1  zero the accumulator of i_cfg_chan
- o_inph, o_quad  out  WIDTH  rotated sample
- o_chan  out  CH_W  channel tag, aligned with output
- o_inph_oflow, o_quad_oflow  out  1  rounded result exceeded WIDTH range
- o_valid  out  1  output strobe

## Operation
- Accepted sample on channel c uses phase θ = acc[c] (pre-update value). In the same cycle, acc[c] <= acc[c] + inc[c] mod 2^PHASE_WIDTH.
- The table address is acc[c][PHASE_WIDTH-1 -: LUT_ADDR] (truncated, no dither). The table is full-cycle with 2^LUT_ADDR entries, built at elaboration: cos/sin(2πk/2^LUT_ADDR)·(2^(COEF_WIDTH-1)-1), rounded to nearest.
- Down-convert: I = i·cos + q·sin, Q = q·cos − i·sin.
- Up-convert: I = i·cos − q·sin, Q = q·cos + i·sin.
- Products are full precision (WIDTH+COEF_WIDTH). Sums are WIDTH+COEF_WIDTH+1 bits.
- Rounding: add 2^(COEF_WIDTH-2), then arithmetic shift right by COEF_WIDTH-1 (round half up).
- Overflow flag is set when the rounded value is outside [−2^(WIDTH-1), 2^(WIDTH-1)−1].
- Config writes:
  - inc[c] changes only via i_cfg_inc_wr.
  - i_cfg_clr sets acc[i_cfg_chan] to 0.
  - Both may assert in the same cycle.
- Simultaneous sample and config on the same channel in the same cycle:
  - The sample uses the old θ and the old inc for its advance.
  - With i_cfg_clr, the accumulator ends at 0; clear wins over the advance.
  - The new inc applies from the next accepted sample.
- Config on one channel never disturbs other channels.

## Timing
- Fixed latency of 6 cycles from i_valid to o_valid. Throughput is 1 sample/cycle, any channel order, including back-to-back on the same channel.
- Pipeline stages:
  - S0: accumulator read/update, LUT address.
  - S1: LUT read.
  - S2: multiply.
  - S3: add/sub.
  - S4: round.
  - S5: saturate/wrap and output register.
- Outputs hold their last value when o_valid = 0.
- Reset values:
  - All acc and inc = 0.
  - o_valid = 0, o_inph = 0, o_quad = 0, o_chan = 0, both oflow = 0.
- Reset mid-stream discards all in-flight samples; no o_valid is produced for them.
- The first sample after reset sees θ = 0 (cos = 2^(COEF_WIDTH-1)−1, sin = 0).

## Configuration
- RX_MIXER_SATURATE_EN defined: out-of-range results clamp to 2^(WIDTH-1)−1 or −2^(WIDTH-1).
- RX_MIXER_SATURATE_EN undefined: outputs are the low WIDTH bits of the rounded value (wrap).
- The oflow flags and latency are identical in both builds.

## Test plan
All scenarios use default parameters.
- Identity: inc = 0, sample (1000, 0) on ch0, down → 6 cycles later (1000, 0), o_chan = 0, no oflow.
- Quarter-turn: inc[0] = 4194304, four consecutive (1000, 0) on ch0, down → (1000, 0), (0, −1000), (−1000, 0), (0, 1000). Same stimulus with i_dir = 1 → Q signs inverted.
- Overflow at 45°:
  - Setup: inc[0] = 2097152; two samples of (32767, 32767), down.
  - Second output with saturation build: I = 32767, o_inph_oflow = 1, Q = 0.
  - Second output with wrap build: I = −19197, o_inph_oflow = 1.
- TDM independence:
  - Setup: inc[0] = 4194304, inc[1] = 0; alternate ch0/ch1 samples of (1000, 0) for 8 cycles.
  - ch1 outputs stay (1000, 0); ch0 follows the quarter-turn sequence.
  - o_chan matches each input tag.
- Same-cycle config: with inc[2] = 0, write inc[2] = 4194304 and send a ch2 sample in the same cycle, then send two more ch2 samples.
  - Phases seen: 0, 0, 90°.
  - Repeat with i_cfg_clr in place of the increment write → accumulator reads 0 next.
- Reset mid-stream: assert i_reset for 1 cycle while 3 samples are in flight → no o_valid for them, outputs 0, next sample uses θ = 0.
